exec_sequencer: RTL

- Multi-cycle control FSM for the nano-cpu core.
- Fetches each instruction from synchronous instruction memory, holds it stable for decode and operand read, and issues a single-cycle start pulse to the multi-cycle ALU.
- Waits for ALU completion, gates the register-file write, advances the PC and counts retired instructions.
- Replaces ad-hoc pc/alu_in_valid logic; adds run/step control, illegal-instruction halt and an ALU watchdog.

---
 rtl/exec_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM for the nano-cpu: fetch, latch, decode check, single ALU
// start pulse, bounded wait for the result, then retire (pc advance + retired count).
module exec_sequencer #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  input  logic                  instr_legal,
  output logic                  alu_in_valid,
  input  logic                  alu_out_valid,
  output logic                  rd_we,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  halted,
  output logic [1:0]            fault_code,
  output logic [31:0]           retired_count,
  output logic [2:0]            dbg_state_o
);

  // Handshake: alu_in_valid is a one-cycle start with no back-pressure; the ALU
  // answers with a one-cycle alu_out_valid, which is only honoured in WAIT.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    DECODE = 3'd3,
    ISSUE  = 3'd4,
    WAIT   = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]             instr_q, instr_d;
  logic [31:0]             ret_q, ret_d;
  logic [1:0]              fault_q, fault_d;
  logic [7:0]              wcnt_q, wcnt_d;
  logic                    single_q, single_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      ret_q    <= '0;
      fault_q  <= 2'd0;
      wcnt_q   <= '0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ret_q    <= ret_d;
      fault_q  <= fault_d;
      wcnt_q   <= wcnt_d;
      single_q <= single_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    ret_d        = ret_q;
    fault_d      = fault_q;
    wcnt_d       = wcnt_q;
    single_d     = single_q;
    alu_in_valid = 1'b0;
    rd_we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (run || step) begin
          state_d  = FETCH;
          single_d = step && !run;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        instr_d = imem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        if (!instr_legal) begin
          state_d = HALT;
          fault_d = 2'd1;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        alu_in_valid = 1'b1;
        wcnt_d       = '0;
        state_d      = WAIT;
      end
      WAIT: begin
        if (alu_out_valid) begin
          rd_we   = 1'b1;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          ret_d   = ret_q + 32'd1;
          state_d = (run && !single_q) ? FETCH : IDLE;
        end else begin
          // The last permitted wait cycle has passed with no result.
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_q == WAIT_LAST) begin
            state_d = HALT;
            fault_d = 2'd2;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (rst) begin
      alu_in_valid = 1'b0;
      rd_we        = 1'b0;
    end
  end

  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign instr         = instr_q;
  assign retired_count = ret_q;
  assign fault_code    = fault_q;
  assign busy          = (state_q != IDLE) && (state_q != HALT);
  assign halted        = (state_q == HALT);
  assign dbg_state_o   = state_q;

endmodule
